// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA-256 decryption controller.
// W is the operand width; CW is the bit-counter width and must satisfy 2^CW > W.
package rsa_pkg;

  localparam int unsigned W  = 256;
  localparam int unsigned CW = 9;
  localparam int unsigned IW = $clog2(W);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    StIdle,
    StPreGo,
    StPreWait,
    StMulGo,
    StMulWait,
    StSqrGo,
    StSqrWait,
    StNext,
    StDone
  } state_e;

  // A set exponent bit needs a multiply before its square; a clear bit goes straight to the square.
  function automatic state_e op_for_bit(input logic bit_val);
    return bit_val ? StMulGo : StSqrGo;
  endfunction

endpackage

// File: rtl/rsa256_ctrl.sv
// Right-to-left square-and-multiply sequencer for m = y^d mod N in the Montgomery domain.
// Owns every operand and result register; the engines are external start/finish compute units.
module rsa256_ctrl
  import rsa_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] n_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] y_i,
  output logic         pre_start_o,
  output logic [W-1:0] pre_n_o,
  output logic [W-1:0] pre_m_o,
  input  logic [W-1:0] pre_t_i,
  input  logic         pre_finish_i,
  output logic         mont_start_o,
  output logic [W-1:0] mont_n_o,
  output logic [W-1:0] mont_a_o,
  output logic [W-1:0] mont_b_o,
  input  logic [W-1:0] mont_r_i,
  input  logic         mont_finish_i,
  output logic [W-1:0] m_o,
  output logic         busy_o,
  output logic         finish_o
);

  state_e          state_q, state_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    t_q, t_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    mont_a_q, mont_a_d;
  logic [W-1:0]    mont_b_q, mont_b_d;
  logic            busy_q, busy_d;
  logic            finish_q, finish_d;
  logic            pre_start_q, pre_start_d;
  logic            mont_start_q, mont_start_d;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    d_d          = d_q;
    y_d          = y_q;
    m_d          = m_q;
    t_d          = t_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    mont_a_d     = mont_a_q;
    mont_b_d     = mont_b_q;
    busy_d       = busy_q;
    finish_d     = 1'b0;
    pre_start_d  = 1'b0;
    mont_start_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          n_d         = n_i;
          d_d         = d_i;
          y_d         = y_i;
          m_d         = ONE;
          cnt_d       = '0;
          busy_d      = 1'b1;
          pre_start_d = 1'b1;
          state_d     = StPreGo;
        end
      end
      StPreGo: state_d = StPreWait;
      StPreWait: begin
        if (pre_finish_i) begin
          t_d     = pre_t_i;
          state_d = op_for_bit(d_q[0]);
        end
      end
      StMulGo: state_d = StMulWait;
      StMulWait: begin
        if (mont_finish_i) begin
          m_d     = mont_r_i;
          state_d = StSqrGo;
        end
      end
      StSqrGo: state_d = StSqrWait;
      StSqrWait: begin
        if (mont_finish_i) begin
          t_d     = mont_r_i;
          state_d = StNext;
        end
      end
      StNext: begin
        if (cnt_q == CW'(W - 1)) begin
          res_d    = m_q;
          finish_d = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = op_for_bit(d_q[cnt_d[IW-1:0]]);
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Operands are launched from next-state values so they are already valid in the GO cycle,
    // including a t or m that is being written on this very edge.
    if (state_d == StMulGo) begin
      mont_start_d = 1'b1;
      mont_a_d     = m_d;
      mont_b_d     = t_d;
    end else if (state_d == StSqrGo) begin
      mont_start_d = 1'b1;
      mont_a_d     = t_d;
      mont_b_d     = t_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      n_q          <= '0;
      d_q          <= '0;
      y_q          <= '0;
      m_q          <= '0;
      t_q          <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      mont_a_q     <= '0;
      mont_b_q     <= '0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      pre_start_q  <= 1'b0;
      mont_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      d_q          <= d_d;
      y_q          <= y_d;
      m_q          <= m_d;
      t_q          <= t_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      mont_a_q     <= mont_a_d;
      mont_b_q     <= mont_b_d;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
      pre_start_q  <= pre_start_d;
      mont_start_q <= mont_start_d;
    end
  end

  assign pre_start_o  = pre_start_q;
  assign pre_n_o      = n_q;
  assign pre_m_o      = y_q;
  assign mont_start_o = mont_start_q;
  assign mont_n_o     = n_q;
  assign mont_a_o     = mont_a_q;
  assign mont_b_o     = mont_b_q;
  assign m_o          = res_q;
  assign busy_o       = busy_q;
  assign finish_o     = finish_q;

endmodule

// File: tb/tb_rsa256_ctrl.sv
// Scoreboard bench for rsa256_ctrl: stub engines with programmable latency, a modular-exponent
// reference model, and a monitor that checks every finish_o against the queued expectation.
module tb_rsa256_ctrl;
  import rsa_pkg::*;

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] dword_t;

  typedef struct {
    word_t m;
    int    calls;
    int    busy;
    word_t first_a;
    word_t first_b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst, start_i;
  word_t n_i, d_i, y_i;
  logic  pre_start_o, pre_finish_i, mont_start_o, mont_finish_i, busy_o, finish_o;
  word_t pre_n_o, pre_m_o, pre_t_i, mont_n_o, mont_a_o, mont_b_o, mont_r_i, m_o;

  logic  eng_pre_fin, eng_mont_fin, stray_fin;
  word_t eng_pre_t, eng_mont_r, stray_r;

  assign pre_finish_i  = eng_pre_fin | stray_fin;
  assign pre_t_i       = stray_fin ? stray_r : eng_pre_t;
  assign mont_finish_i = eng_mont_fin | stray_fin;
  assign mont_r_i      = stray_fin ? stray_r : eng_mont_r;

  rsa256_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .n_i           (n_i),
    .d_i           (d_i),
    .y_i           (y_i),
    .pre_start_o   (pre_start_o),
    .pre_n_o       (pre_n_o),
    .pre_m_o       (pre_m_o),
    .pre_t_i       (pre_t_i),
    .pre_finish_i  (pre_finish_i),
    .mont_start_o  (mont_start_o),
    .mont_n_o      (mont_n_o),
    .mont_a_o      (mont_a_o),
    .mont_b_o      (mont_b_o),
    .mont_r_i      (mont_r_i),
    .mont_finish_i (mont_finish_i),
    .m_o           (m_o),
    .busy_o        (busy_o),
    .finish_o      (finish_o)
  );

  int checks = 0;
  int passes = 0;
  int lp = 2, lm = 3, hold = 1;
  int pre_stab = 0, mont_stab = 0, stab_base = 0;
  int done_cnt = 0, total_mont = 0;
  int run_calls = 0, run_busy = 0, run_pre = 0;
  exp_t sb[$];

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic word_t modmul(input word_t a, input word_t b, input word_t n);
    dword_t p;
    p = dword_t'(a) * dword_t'(b);
    return word_t'(p % dword_t'(n));
  endfunction

  function automatic word_t modexp(input word_t y, input word_t d, input word_t n);
    word_t r = ONE;
    word_t b = y;
    for (int i = 0; i < W; i++) begin
      if (d[i]) r = modmul(r, b, n);
      b = modmul(b, b, n);
    end
    return r;
  endfunction

  function automatic word_t to_mont(input word_t y, input word_t n);
    dword_t p;
    p = {y, {W{1'b0}}};
    return word_t'(p % dword_t'(n));
  endfunction

  // Engine stub: bit-serial a*b*2^-W mod n.
  function automatic word_t mont_eng(input word_t a, input word_t b, input word_t n);
    logic [W+1:0] r = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) r = r + {2'b00, b};
      if (r[0]) r = r + {2'b00, n};
      r = r >> 1;
    end
    if (r >= {2'b00, n}) r = r - {2'b00, n};
    return r[W-1:0];
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic word_t rand_mod();
    word_t w = rand_word();
    w[W-1] = 1'b1;
    w[0]   = 1'b1;
    return w;
  endfunction

  // ---------------- engine stubs ----------------
  initial begin : pre_engine
    word_t pn, py, pr;
    bit    ab;
    eng_pre_fin = 1'b0;
    eng_pre_t   = '0;
    forever begin
      @(negedge clk);
      if (pre_start_o && !rst) begin
        pn = pre_n_o;
        py = pre_m_o;
        pr = to_mont(py, pn);
        ab = 1'b0;
        for (int k = 0; k < lp; k++) begin
          @(negedge clk);
          if (rst) begin ab = 1'b1; break; end
          if (pre_n_o !== pn || pre_m_o !== py) pre_stab++;
        end
        if (!ab) begin
          eng_pre_t   = pr;
          eng_pre_fin = 1'b1;
          for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (rst) break;
          end
          eng_pre_fin = 1'b0;
        end
      end
    end
  end

  initial begin : mont_engine
    word_t ma, mb, mn, mr;
    bit    have, ab;
    eng_mont_fin = 1'b0;
    eng_mont_r   = '0;
    have         = 1'b0;
    forever begin
      if (!have) begin
        @(negedge clk);
        have = mont_start_o && !rst;
      end
      if (have) begin
        have = 1'b0;
        ma = mont_a_o;
        mb = mont_b_o;
        mn = mont_n_o;
        mr = mont_eng(ma, mb, mn);
        ab = 1'b0;
        for (int k = 0; k < lm; k++) begin
          @(negedge clk);
          if (rst) begin ab = 1'b1; break; end
          if (mont_a_o !== ma || mont_b_o !== mb || mont_n_o !== mn) mont_stab++;
        end
        if (!ab) begin
          eng_mont_r   = mr;
          eng_mont_fin = 1'b1;
          // A level finish is held until the hold expires or the next start arrives.
          for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (rst) break;
            if (mont_start_o) begin have = 1'b1; break; end
          end
          eng_mont_fin = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_calls = 0;
        run_busy  = 0;
        run_pre   = 0;
      end else begin
        if (pre_start_o) run_pre++;
        if (mont_start_o) begin
          if (run_calls == 0 && sb.size() > 0) begin
            check("first_mont_a", mont_a_o, sb[0].first_a);
            check("first_mont_b", mont_b_o, sb[0].first_b);
          end
          run_calls++;
          total_mont++;
        end
        if (busy_o) run_busy++;
        if (finish_o) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_finish: m_o=%h with no request pending", m_o);
          end else begin
            e = sb.pop_front();
            check("m_o", m_o, e.m);
            check_int("mont_calls", run_calls, e.calls);
            check_int("busy_cycles", run_busy, e.busy);
            check_int("pre_calls", run_pre, 1);
            check_int("operand_stability", pre_stab + mont_stab - stab_base, 0);
          end
          stab_base = pre_stab + mont_stab;
          done_cnt++;
          run_calls = 0;
          run_busy  = 0;
          run_pre   = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int run_bound(input word_t d);
    return 40 + lp + W * (2 * (lm + 1) + 1) + W * hold;
  endfunction

  task automatic issue(input word_t n, input word_t d, input word_t y);
    exp_t  e;
    word_t t0 = to_mont(y, n);
    int    sum = 0;
    for (int i = 0; i < W; i++) sum += (1 + lm) * (d[i] ? 2 : 1) + 1;
    e.m       = modexp(y, d, n);
    e.calls   = W + $countones(d);
    e.busy    = (1 + lp) + sum + 1;
    e.first_a = d[0] ? ONE : t0;
    e.first_b = t0;
    sb.push_back(e);
    n_i     = n;
    d_i     = d;
    y_i     = y;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_i     = rand_word();
    d_i     = rand_word();
    y_i     = rand_word();
  endtask

  task automatic wait_done(input string name, input int target, input int bound);
    int k = 0;
    while (done_cnt < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) begin
      checks++;
      $display("FAIL %s_timeout: done=%0d after %0d cycles, want %0d", name, done_cnt, k, target);
      sb.delete();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_mont(input string name, input int target, input int bound);
    int k = 0;
    while (total_mont < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (total_mont < target) begin
      checks++;
      $display("FAIL %s_timeout: mont calls %0d, want %0d", name, total_mont, target);
    end
  endtask

  task automatic run_op(input string name, input word_t n, input word_t d, input word_t y);
    int base = done_cnt;
    issue(n, d, y);
    wait_done(name, base + 1, run_bound(d));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m_o"}, m_o, '0);
    check({tag, "_pre_n_o"}, pre_n_o, '0);
    check({tag, "_pre_m_o"}, pre_m_o, '0);
    check({tag, "_mont_n_o"}, mont_n_o, '0);
    check({tag, "_mont_a_o"}, mont_a_o, '0);
    check({tag, "_mont_b_o"}, mont_b_o, '0);
    check({tag, "_busy_o"}, word_t'(busy_o), '0);
    check({tag, "_finish_o"}, word_t'(finish_o), '0);
    check({tag, "_pre_start_o"}, word_t'(pre_start_o), '0);
    check({tag, "_mont_start_o"}, word_t'(mont_start_o), '0);
  endtask

  initial begin : main
    word_t n, y, d;
    int    base;
    rst       = 1'b1;
    start_i   = 1'b0;
    n_i       = '0;
    d_i       = '0;
    y_i       = '0;
    stray_fin = 1'b0;
    stray_r   = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // d = 0: all squares, result 1
    n = rand_mod(); y = rand_word() % n;
    lp = 2; lm = 3; hold = 1;
    run_op("d_zero", n, '0, y);

    // d = all ones, with a stray start pulse landing in MUL_WAIT
    n = rand_mod(); y = rand_word() % n;
    lp = 4; lm = 3; hold = 1;
    base = done_cnt;
    issue(n, '1, y);
    wait_mont("ones_first_mul", total_mont + 1, 50);
    @(negedge clk);
    n_i = rand_mod(); d_i = rand_word(); y_i = rand_word();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("d_ones", base + 1, run_bound('1));
    check_int("ignored_start_no_extra_run", done_cnt, base + 1);

    // d = 1 with fixed engine latencies
    n = rand_mod(); y = rand_word() % n;
    lp = 3; lm = 5; hold = 1;
    run_op("d_one", n, ONE, y);

    // random exponents and latencies
    for (int r = 0; r < 3; r++) begin
      n = rand_mod(); y = rand_word() % n; d = rand_word();
      lp = $urandom_range(1, 4); lm = $urandom_range(1, 4); hold = 1;
      run_op("random", n, d, y);
    end

    // level-held finish
    n = rand_mod(); y = rand_word() % n; d = rand_word();
    lp = 3; lm = 3; hold = 4;
    run_op("level_finish", n, d, y);

    // reset in the middle of a square, then stray finishes
    n = rand_mod(); y = rand_word() % n;
    lp = 2; lm = 5; hold = 1;
    base = done_cnt;
    issue(n, '0, y);
    wait_mont("rst_mid_sqr", total_mont + 3, 400);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_rst");
    stray_r   = rand_word();
    stray_fin = 1'b1;
    repeat (3) @(negedge clk);
    stray_fin = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("after_stray");
    check_int("no_finish_after_rst", done_cnt, base);

    // recovery after reset
    n = rand_mod(); y = rand_word() % n; d = rand_word();
    lp = 2; lm = 2; hold = 1;
    run_op("after_rst_run", n, d, y);
    check("m_o_held", m_o, modexp(y, d, n));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
